// File: rtl/wisc_pkg.sv
// wisc_pkg: shared WISC opcode and immediate-kind encodings.
//   Opcodes live in instr[15:12]; immediate kinds are reported on imm_kind.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [1:0] IMM_NONE = 2'd0;
    localparam logic [1:0] IMM_S4   = 2'd1;
    localparam logic [1:0] IMM_U8   = 2'd2;
    localparam logic [1:0] IMM_S9   = 2'd3;

endpackage

// File: rtl/imm_ext_comb.sv
// imm_ext_comb: combinational immediate classification and extension.
//   instr   in  16      instruction word, opcode in [15:12]
//   kind    out 2       IMM_NONE / IMM_S4 / IMM_U8 / IMM_S9
//   imm     out DATA_W  extended or positioned immediate
//   byte_hi out 1       immediate occupies the upper byte (LHB)
module imm_ext_comb
    import wisc_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int MEM_OFF_SHIFT = 1
) (
    input  logic [15:0]       instr,
    output logic [1:0]        kind,
    output logic [DATA_W-1:0] imm,
    output logic              byte_hi
);

    logic [3:0]        op;
    logic [DATA_W-1:0] s4;
    logic [DATA_W-1:0] u8;
    logic [DATA_W-1:0] s9;
    logic              unused_bits;

    assign op = instr[15:12];
    // Signed casts widen with sign extension; unsigned ones zero-fill.
    assign s4 = DATA_W'($signed(instr[3:0]));
    assign u8 = DATA_W'(instr[7:0]);
    assign s9 = DATA_W'($signed(instr[8:0]));
    // No immediate format reaches bits [11:9].
    assign unused_bits = ^instr[11:9];

    always_comb begin
        kind    = IMM_NONE;
        imm     = '0;
        byte_hi = 1'b0;
        case (op)
            OP_SLL, OP_SRA, OP_ROR: begin
                kind = IMM_S4;
                imm  = s4;
            end
            OP_LW, OP_SW: begin
                kind = IMM_S4;
                imm  = s4 << MEM_OFF_SHIFT;
            end
            OP_LHB: begin
                kind    = IMM_U8;
                imm     = u8 << 8;
                byte_hi = 1'b1;
            end
            OP_LLB: begin
                kind = IMM_U8;
                imm  = u8;
            end
            OP_B: begin
                kind = IMM_S9;
                imm  = s9;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: immediate extension + branch target stage with a one-entry handshake register.
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        decode-side handshake; in_ready = !out_valid | out_ready
//   instr, pc                instruction word and its address
//   flush                    squash held entry and block this cycle's load
//   out_valid/out_ready      execute-side handshake
//   opcode_out, imm_kind,
//   imm_out, byte_hi,
//   br_target                registered results (data not cleared on flush/drain)
module imm_ext_stage
    import wisc_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int MEM_OFF_SHIFT = 1,
    parameter int BR_SHIFT      = 1,
    parameter int PC_INC        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        opcode_out,
    output logic [1:0]        imm_kind,
    output logic [DATA_W-1:0] imm_out,
    output logic              byte_hi,
    output logic [DATA_W-1:0] br_target
);

    logic [1:0]        kind_d;
    logic [DATA_W-1:0] imm_d;
    logic              byte_hi_d;
    logic [DATA_W-1:0] br_target_d;
    logic [DATA_W-1:0] br_off;
    logic              load;
    logic              out_valid_d;

    logic              out_valid_q;
    logic [3:0]        opcode_q;
    logic [1:0]        kind_q;
    logic [DATA_W-1:0] imm_q;
    logic              byte_hi_q;
    logic [DATA_W-1:0] br_target_q;

    imm_ext_comb #(
        .DATA_W        (DATA_W),
        .MEM_OFF_SHIFT (MEM_OFF_SHIFT)
    ) u_ext (
        .instr   (instr),
        .kind    (kind_d),
        .imm     (imm_d),
        .byte_hi (byte_hi_d)
    );

    // For B the extender already yields sext9, so only the scaling is left here.
    assign br_off      = (kind_d == IMM_S9) ? (imm_d << BR_SHIFT) : '0;
    assign br_target_d = pc + DATA_W'(PC_INC) + br_off;

    assign in_ready    = !out_valid_q | out_ready;
    assign load        = in_valid & in_ready & !flush;
    assign out_valid_d = flush ? 1'b0 : load ? 1'b1 : out_ready ? 1'b0 : out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            kind_q      <= '0;
            imm_q       <= '0;
            byte_hi_q   <= 1'b0;
            br_target_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                opcode_q    <= instr[15:12];
                kind_q      <= kind_d;
                imm_q       <= imm_d;
                byte_hi_q   <= byte_hi_d;
                br_target_q <= br_target_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign opcode_out = opcode_q;
    assign imm_kind   = kind_q;
    assign imm_out    = imm_q;
    assign byte_hi    = byte_hi_q;
    assign br_target  = br_target_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed-vector self-checking bench for imm_ext_stage.
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode_out;
    logic [1:0]  imm_kind;
    logic [15:0] imm_out;
    logic        byte_hi;
    logic [15:0] br_target;

    int n_vec = 0;
    int n_bad = 0;

    imm_ext_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opcode_out (opcode_out),
        .imm_kind   (imm_kind),
        .imm_out    (imm_out),
        .byte_hi    (byte_hi),
        .br_target  (br_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] op, input logic [1:0] kind,
                             input logic [15:0] imm, input logic bh, input logic [15:0] br);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".op"}, 32'(opcode_out), 32'(op));
        check({tag, ".kind"}, 32'(imm_kind), 32'(kind));
        check({tag, ".imm"}, 32'(imm_out), 32'(imm));
        check({tag, ".bh"}, 32'(byte_hi), 32'(bh));
        check({tag, ".br"}, 32'(br_target), 32'(br));
    endtask

    task automatic apply(input logic [15:0] i, input logic [15:0] p);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
        #2;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.imm", 32'(imm_out), 32'd0);
        check("rst.br", 32'(br_target), 32'd0);
        check("rst.kind", 32'(imm_kind), 32'd0);
        check("rst.rdy", 32'(in_ready), 32'd1);
        #20 rst_n = 1'b1;
        tick();

        apply(16'h800F, 16'h0010); tick(); check_out("lw", 4'h8, 2'd1, 16'hFFFE, 1'b0, 16'h0012);
        apply(16'hC1FF, 16'h0000); tick(); check_out("b_neg", 4'hC, 2'd3, 16'hFFFF, 1'b0, 16'h0000);
        apply(16'hC0FF, 16'hFFFE); tick(); check_out("b_wrap", 4'hC, 2'd3, 16'h00FF, 1'b0, 16'h01FE);
        apply(16'hA0AB, 16'h0100); tick(); check_out("lhb", 4'hA, 2'd2, 16'hAB00, 1'b1, 16'h0102);
        apply(16'hB0AB, 16'h0100); tick(); check_out("llb", 4'hB, 2'd2, 16'h00AB, 1'b0, 16'h0102);
        apply(16'h4008, 16'h0200); tick(); check_out("sll", 4'h4, 2'd1, 16'hFFF8, 1'b0, 16'h0202);
        apply(16'h9007, 16'h0300); tick(); check_out("sw", 4'h9, 2'd1, 16'h000E, 1'b0, 16'h0302);

        // stall: held entry must not change while new input waits
        apply(16'h4003, 16'h0040); tick(); check_out("stl0", 4'h4, 2'd1, 16'h0003, 1'b0, 16'h0042);
        out_ready = 1'b0;
        apply(16'hB055, 16'h0050);
        #1 check("stl.rdy", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("stl", 4'h4, 2'd1, 16'h0003, 1'b0, 16'h0042);
            check("stl.rdy_hold", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1 check("stl.rdy_rel", 32'(in_ready), 32'd1);
        tick(); check_out("stl_ld", 4'hB, 2'd2, 16'h0055, 1'b0, 16'h0052);
        in_valid = 1'b0;
        tick();
        check("drain.valid", 32'(out_valid), 32'd0);
        check("drain.imm", 32'(imm_out), 32'h0055);

        // flush beats both hold and load
        apply(16'hA012, 16'h0000); tick(); check_out("fl0", 4'hA, 2'd2, 16'h1200, 1'b1, 16'h0002);
        out_ready = 1'b0; flush = 1'b1;
        apply(16'hB034, 16'h0000); tick();
        check("flush.valid", 32'(out_valid), 32'd0);
        check("flush.imm", 32'(imm_out), 32'h1200);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("flush.after", 32'(out_valid), 32'd0);

        // asynchronous reset mid-stall
        apply(16'h800F, 16'h0010); tick(); check_out("ar0", 4'h8, 2'd1, 16'hFFFE, 1'b0, 16'h0012);
        out_ready = 1'b0; in_valid = 1'b1; instr = 16'hB011;
        tick();
        check("ar.stall", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.imm", 32'(imm_out), 32'd0);
        check("ar.br", 32'(br_target), 32'd0);
        check("ar.op", 32'(opcode_out), 32'd0);
        check("ar.rdy", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("post.rdy", 32'(in_ready), 32'd1);

        apply(16'h7123, 16'h0020); tick(); check_out("paddsb", 4'h7, 2'd0, 16'h0000, 1'b0, 16'h0022);
        apply(16'hF000, 16'h0030); tick(); check_out("hlt", 4'hF, 2'd0, 16'h0000, 1'b0, 16'h0032);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
